carrier_start_sequencer: RTL and testbench
==========================================

Name: carrier_start_sequencer

Overview:
- Sequences start-up, shutdown and configuration commits for a cluster of NCARR carrier channels. Each channel is a carrier generator, mask-event logic, event counter and masked shadow registers.
- Drives the common pwm_onoff and per-channel carrier_onoff enables, and emits a cfg_load strobe that forces the masked registers to capture.
- Acknowledges software commits only on a mask-event boundary.
- Runs a mask-event watchdog that trips a fault latch.
- Sits between the AXI4-lite register file and the carrier cluster.

Parameters:
- NCARR, 8, number of carrier channels sequenced.
- STAG_W, 16, width of the stagger delay counter.
- WDOG_W, 24, width of the watchdog counter and limit.
- LOAD_CYCLES, 2, cycles cfg_load is held in LOAD state (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start_req  in  1  start pulse or level; sampled in IDLE.
- stop_req  in  1  graceful stop request; also clears FAULT.
- estop  in  1  emergency stop, level.
- carr_enable  in  NCARR  channels to start; latched on IDLE->LOAD.
- stagger  in  STAG_W  cycles inserted between successive channel enables.
- wdog_lim  in  WDOG_W  watchdog limit; 0 disables the watchdog.
- maskevent  in  NCARR  per-channel mask-event pulses from the event counters.
- cfg_commit_req  in  1  software commit request pulse.
- cfg_commit_ack  out  1  one-cycle acknowledge.
- cfg_load  out  1  forced capture strobe to the masked registers.
- pwm_onoff  out  _pwm_onoff  cluster enable.
- carrier_onoff  out  NCARR x _carr_onoff  per-channel enable.
- seq_state  out  3  current state encoding.
- busy  out  1  high in LOAD, STAGGER, DRAIN.
- fault  out  1  high in FAULT.

Behaviour:
- All outputs are registered.
- Reset values: pwm_onoff=OFF, all carrier_onoff=OFF, cfg_load=0, cfg_commit_ack=0, fault=0, busy=0, seq_state=IDLE. All counters, the latched mask and commit_pending are 0.
- States: IDLE=0, LOAD=1, STAGGER=2, RUN=3, DRAIN=4, FAULT=5.
- Event priority, highest first: estop, watchdog expiry, stop_req, commit.
- ref channel = lowest set bit of the latched mask en_q.
- IDLE:
  - start_req=1, carr_enable!=0 and estop=0 -> LOAD; latch en_q=carr_enable.
  - start_req with carr_enable=0 is ignored.
  - cfg_commit_req -> next cycle cfg_load=1 and cfg_commit_ack=1, both for 1 cycle.
- LOAD:
  - cfg_load=1 for exactly LOAD_CYCLES cycles.
  - On the last cycle, pwm_onoff<=ON, idx<=0, stagger counter<=0, then -> STAGGER.
- STAGGER:
  - Walks idx from 0 to NCARR-1.
  - If en_q[idx]=1: carrier_onoff[idx]<=ON, then wait stagger cycles before advancing. stagger=0 enables one channel per cycle.
  - If en_q[idx]=0: advance in 1 cycle with no wait.
  - Leaving idx=NCARR-1 -> RUN.
  - stop_req received in STAGGER is held pending and taken on RUN entry.
- RUN:
  - cfg_commit_req sets commit_pending.
  - While commit_pending=1, maskevent[ref]=1 -> cfg_commit_ack=1 next cycle; pending cleared.
  - Request and maskevent in the same cycle: the ack waits for the next maskevent[ref].
  - A second request while pending is merged into the same pending commit.
  - stop_req -> DRAIN.
- DRAIN:
  - Wait for maskevent[ref]. On it, next cycle: all carrier_onoff=OFF, pwm_onoff=OFF, en_q cleared -> IDLE.
  - A pending commit is acked on the same edge.
- Watchdog (RUN and DRAIN only):
  - Counter clears on any maskevent&en_q and otherwise increments, saturating.
  - Counter == wdog_lim with wdog_lim!=0 -> FAULT.
- FAULT entry (estop in any non-IDLE state, or watchdog expiry):
  - Next cycle all enables are OFF, cfg_load=0, commit_pending is dropped without ack, fault=1.
- FAULT exit: stop_req=1 with estop=0 -> IDLE with fault=0. start_req is ignored in FAULT.
- estop in IDLE blocks start only; it does not enter FAULT.
- Counter widths: stagger and watchdog counters are unsigned and saturate, never wrap. idx is clog2(NCARR) bits.

Decomposition:
- PKG_pwm additions: a _seq_state enum (6 values, 3 bits) and the STAG_W/WDOG_W width macros, alongside the existing _pwm_onoff/_carr_onoff.
- One natural sub-module, seq_watchdog: clear, enable, limit, expire pulse. Reusable for other PWM blocks.
- The FSM, stagger walker and commit logic stay in the top module.

Test Plan:
- Start/stagger: carr_enable=8'b0000_0101, stagger=3, LOAD_CYCLES=2, start_req. Required: cfg_load high cycles 1-2 after start, pwm_onoff ON after cycle 2, carrier 0 ON, carrier 2 ON 5 cycles later (3 waits + 1 skip + 1), seq_state=RUN after that.
- Commit in RUN: request at t=10, maskevent[0] at t=25. Required: cfg_commit_ack a single pulse at t=26 and no ack before. A second request at t=12 yields no second ack.
- Drain: stop_req in RUN, maskevent[0] 7 cycles later. Required: all enables OFF the following cycle, seq_state=IDLE, busy low.
- Watchdog: wdog_lim=100, RUN with no maskevents. Required: fault=1 and all OFF at cycle 101. Then stop_req -> IDLE, fault=0.
- estop during STAGGER (after 1 of 3 channels is on). Required: next cycle all OFF, seq_state=FAULT. start_req ignored until stop_req with estop=0.
- Async reset asserted mid-RUN with a commit pending. Required: outputs at reset values immediately, no ack after reset release.

Source files
------------

// File: rtl/carrier_start_sequencer_pkg.sv
// Shared types and width defaults for the carrier start sequencer.
// No logic: enums for the enable polarities and the sequencer state encoding.
// No flow control; pure type definitions.
package carrier_start_sequencer_pkg;

    localparam int STAG_W_DEF = 16;
    localparam int WDOG_W_DEF = 24;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } pwm_onoff_t;

    typedef enum logic {
        CARR_OFF = 1'b0,
        CARR_ON  = 1'b1
    } carr_onoff_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_STAGGER = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_FAULT   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/carrier_start_sequencer_seq_watchdog.sv
// Mask-event watchdog: counts cycles without activity, flags when the count hits the limit.
// Latency: expire asserts combinationally in the cycle the registered count equals limit.
// No backpressure; clear wins over expiry so an event landing on the limit cycle rescues it.
module carrier_start_sequencer_seq_watchdog #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Saturating idle counter, held at zero whenever the watchdog is disabled or kicked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || clear) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A zero limit disables expiry entirely.
    assign expire = enable && !clear && (limit != '0) && (cnt == limit);

endmodule

// File: rtl/carrier_start_sequencer.sv
// Start/stop/commit sequencer for a cluster of carrier channels with staggered enables.
// Latency: all outputs registered; state changes and strobes appear one cycle after the cause.
// No backpressure; commits are held pending and acked only on a reference-channel mask event.
module carrier_start_sequencer
    import carrier_start_sequencer_pkg::*;
#(
    parameter int NCARR       = 8,
    parameter int STAG_W      = STAG_W_DEF,
    parameter int WDOG_W      = WDOG_W_DEF,
    parameter int LOAD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic              estop,
    input  logic [NCARR-1:0]  carr_enable,
    input  logic [STAG_W-1:0] stagger,
    input  logic [WDOG_W-1:0] wdog_lim,
    input  logic [NCARR-1:0]  maskevent,
    input  logic              cfg_commit_req,
    output logic              cfg_commit_ack,
    output logic              cfg_load,
    output pwm_onoff_t        pwm_onoff,
    output logic [NCARR-1:0]  carrier_onoff,
    output logic [2:0]        seq_state,
    output logic              busy,
    output logic              fault
);

    localparam int IDX_W  = (NCARR > 1) ? $clog2(NCARR) : 1;
    localparam int LOAD_W = $clog2(LOAD_CYCLES + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NCARR - 1);
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);

    seq_state_t         state;
    logic [NCARR-1:0]   en_q;
    logic [IDX_W-1:0]   idx;
    logic [STAG_W-1:0]  stag_cnt;
    logic [LOAD_W-1:0]  load_cnt;
    logic               commit_pending;
    logic               stop_pending;

    logic [IDX_W-1:0]   ref_idx;
    logic               ref_evt;
    logic               commit_fire;
    logic [STAG_W:0]    stag_cnt_inc;
    logic               wait_done;
    logic               chan_on_now;
    logic               walk_step;
    logic               wdog_en;
    logic               wdog_clear;
    logic               wdog_expire;
    logic               fault_trip;

    assign seq_state = state;

    // Reference channel is the lowest enabled channel; its mask event marks commit boundaries.
    always_comb begin
        ref_idx = '0;
        for (int i = NCARR - 1; i >= 0; i--) begin
            if (en_q[i]) begin
                ref_idx = IDX_W'(i);
            end
        end
    end

    assign ref_evt     = maskevent[ref_idx] && (en_q != '0);
    assign commit_fire = commit_pending && ref_evt;

    // Stagger walker decisions: turn the current channel on, then wait, or skip disabled ones.
    always_comb begin
        stag_cnt_inc = {1'b0, stag_cnt} + 1'b1;
        wait_done    = stag_cnt_inc >= {1'b0, stagger};
        chan_on_now  = en_q[idx] && !carrier_onoff[idx];
        if (!en_q[idx]) begin
            walk_step = 1'b1;
        end else if (chan_on_now) begin
            walk_step = (stagger == '0);
        end else begin
            walk_step = wait_done;
        end
    end

    assign wdog_en    = (state == ST_RUN) || (state == ST_DRAIN);
    assign wdog_clear = (maskevent & en_q) != '0;

    carrier_start_sequencer_seq_watchdog #(
        .W (WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wdog_clear),
        .enable (wdog_en),
        .limit  (wdog_lim),
        .expire (wdog_expire)
    );

    // Emergency stop only trips out of an active sequence; in IDLE it merely blocks start.
    assign fault_trip = (estop && (state != ST_IDLE) && (state != ST_FAULT)) || wdog_expire;

    // Main sequencer: state, walker, commit tracking and every registered output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            en_q           <= '0;
            idx            <= '0;
            stag_cnt       <= '0;
            load_cnt       <= '0;
            commit_pending <= 1'b0;
            stop_pending   <= 1'b0;
            cfg_commit_ack <= 1'b0;
            cfg_load       <= 1'b0;
            pwm_onoff      <= PWM_OFF;
            carrier_onoff  <= '0;
            busy           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            cfg_commit_ack <= 1'b0;
            if (fault_trip) begin
                state          <= ST_FAULT;
                en_q           <= '0;
                commit_pending <= 1'b0;
                stop_pending   <= 1'b0;
                cfg_load       <= 1'b0;
                pwm_onoff      <= PWM_OFF;
                carrier_onoff  <= '0;
                busy           <= 1'b0;
                fault          <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cfg_load       <= cfg_commit_req;
                        cfg_commit_ack <= cfg_commit_req;
                        if (start_req && (carr_enable != '0) && !estop) begin
                            state    <= ST_LOAD;
                            en_q     <= carr_enable;
                            load_cnt <= '0;
                            cfg_load <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end

                    ST_LOAD: begin
                        commit_pending <= commit_pending || cfg_commit_req;
                        stop_pending   <= stop_pending || stop_req;
                        if (load_cnt == LOAD_LAST) begin
                            cfg_load  <= 1'b0;
                            pwm_onoff <= PWM_ON;
                            idx       <= '0;
                            stag_cnt  <= '0;
                            state     <= ST_STAGGER;
                        end else begin
                            cfg_load <= 1'b1;
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end

                    ST_STAGGER: begin
                        commit_pending <= commit_pending || cfg_commit_req;
                        stop_pending   <= stop_pending || stop_req;
                        if (chan_on_now) begin
                            carrier_onoff[idx] <= CARR_ON;
                        end
                        if (walk_step) begin
                            stag_cnt <= '0;
                            if (idx == IDX_LAST) begin
                                state <= ST_RUN;
                                busy  <= 1'b0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else if (chan_on_now) begin
                            stag_cnt <= '0;
                        end else if (stag_cnt != '1) begin
                            stag_cnt <= stag_cnt + 1'b1;
                        end
                    end

                    ST_RUN: begin
                        // A request landing with the event waits for the following event.
                        commit_pending <= cfg_commit_req || (commit_pending && !commit_fire);
                        cfg_commit_ack <= commit_fire;
                        if (stop_req || stop_pending) begin
                            state        <= ST_DRAIN;
                            stop_pending <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end

                    ST_DRAIN: begin
                        if (ref_evt) begin
                            cfg_commit_ack <= commit_pending || cfg_commit_req;
                            commit_pending <= 1'b0;
                            pwm_onoff      <= PWM_OFF;
                            carrier_onoff  <= '0;
                            en_q           <= '0;
                            busy           <= 1'b0;
                            state          <= ST_IDLE;
                        end else begin
                            commit_pending <= commit_pending || cfg_commit_req;
                        end
                    end

                    ST_FAULT: begin
                        if (stop_req && !estop) begin
                            state <= ST_IDLE;
                            fault <= 1'b0;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_carrier_start_sequencer.sv
// Directed bench for carrier_start_sequencer: vector table for IDLE/start/stagger,
// then hand sequences for commit, drain, watchdog, estop and async reset.
// Expected values are hand-derived cycle by cycle.
module tb_carrier_start_sequencer;
    import carrier_start_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        start_req, stop_req, estop, cfg_commit_req;
    logic [7:0]  carr_enable, maskevent;
    logic [15:0] stagger;
    logic [23:0] wdog_lim;
    logic        cfg_commit_ack, cfg_load, busy, fault;
    pwm_onoff_t  pwm_onoff;
    logic [7:0]  carrier_onoff;
    logic [2:0]  seq_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       start, stop, es, cmt;
        logic [7:0] en, mev;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       ld, ack, pwm;
        logic [7:0] carr;
        logic       bsy, flt;
    } resp_t;

    typedef struct packed {
        stim_t s;
        resp_t r;
    } vec_t;

    vec_t vecs[22];

    carrier_start_sequencer #(
        .NCARR       (8),
        .STAG_W      (16),
        .WDOG_W      (24),
        .LOAD_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_req      (start_req),
        .stop_req       (stop_req),
        .estop          (estop),
        .carr_enable    (carr_enable),
        .stagger        (stagger),
        .wdog_lim       (wdog_lim),
        .maskevent      (maskevent),
        .cfg_commit_req (cfg_commit_req),
        .cfg_commit_ack (cfg_commit_ack),
        .cfg_load       (cfg_load),
        .pwm_onoff      (pwm_onoff),
        .carrier_onoff  (carrier_onoff),
        .seq_state      (seq_state),
        .busy           (busy),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic resp_t rsp(logic [2:0] st, logic ld, logic ack, logic pwm,
                                  logic [7:0] carr, logic bsy, logic flt);
        return {st, ld, ack, pwm, carr, bsy, flt};
    endfunction

    function automatic vec_t mk(logic s, logic p, logic e, logic c, logic [7:0] en,
                                logic [7:0] mev, resp_t r);
        return {s, p, e, c, en, mev, r};
    endfunction

    function automatic resp_t obs();
        return {seq_state, cfg_load, cfg_commit_ack, (pwm_onoff == PWM_ON),
                carrier_onoff, busy, fault};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_up(input logic [7:0] en, input logic [15:0] stg);
        int n;
        carr_enable = en;
        stagger     = stg;
        start_req   = 1'b1;
        step();
        start_req = 1'b0;
        n = 0;
        while (seq_state != 3'd3 && n < 200) begin
            step();
            n++;
        end
        chk("run_up_reached_run", 32'(seq_state), 32'd3);
    endtask

    initial begin
        reset          = 1'b0;
        start_req      = 1'b0;
        stop_req       = 1'b0;
        estop          = 1'b0;
        cfg_commit_req = 1'b0;
        carr_enable    = 8'h00;
        maskevent      = 8'h00;
        stagger        = 16'd3;
        wdog_lim       = 24'd0;

        // IDLE behaviour, then start with channels 0 and 2 at stagger 3.
        vecs[0] = mk(0, 0, 0, 0, 8'h00, 8'h00, rsp(3'd0, 0, 0, 0, 8'h00, 0, 0));
        vecs[1] = mk(0, 0, 0, 1, 8'h00, 8'h00, rsp(3'd0, 1, 1, 0, 8'h00, 0, 0));
        vecs[2] = mk(0, 0, 0, 0, 8'h00, 8'h00, rsp(3'd0, 0, 0, 0, 8'h00, 0, 0));
        vecs[3] = mk(1, 0, 0, 0, 8'h00, 8'h00, rsp(3'd0, 0, 0, 0, 8'h00, 0, 0));
        vecs[4] = mk(1, 0, 1, 0, 8'h05, 8'h00, rsp(3'd0, 0, 0, 0, 8'h00, 0, 0));
        vecs[5] = mk(1, 0, 0, 0, 8'h05, 8'h00, rsp(3'd1, 1, 0, 0, 8'h00, 1, 0));
        vecs[6] = mk(0, 0, 0, 0, 8'h05, 8'h00, rsp(3'd1, 1, 0, 0, 8'h00, 1, 0));
        vecs[7] = mk(0, 0, 0, 0, 8'h05, 8'h00, rsp(3'd2, 0, 0, 1, 8'h00, 1, 0));
        for (int i = 8; i <= 12; i++)
            vecs[i] = mk(0, 0, 0, 0, 8'h05, 8'h00, rsp(3'd2, 0, 0, 1, 8'h01, 1, 0));
        for (int i = 13; i <= 20; i++)
            vecs[i] = mk(0, 0, 0, 0, 8'h05, 8'h00, rsp(3'd2, 0, 0, 1, 8'h05, 1, 0));
        vecs[21] = mk(0, 0, 0, 0, 8'h05, 8'h00, rsp(3'd3, 0, 0, 1, 8'h05, 0, 0));

        step();
        chk("reset_state", 32'(obs()), 32'(rsp(3'd0, 0, 0, 0, 8'h00, 0, 0)));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            start_req      = vecs[i].s.start;
            stop_req       = vecs[i].s.stop;
            estop          = vecs[i].s.es;
            cfg_commit_req = vecs[i].s.cmt;
            carr_enable    = vecs[i].s.en;
            maskevent      = vecs[i].s.mev;
            step();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].r));
        end
        start_req = 1'b0;

        // Commit in RUN: merged requests, non-reference event ignored, same-cycle request deferred.
        for (int t = 0; t < 35; t++) begin
            cfg_commit_req = (t == 10 || t == 12 || t == 28);
            maskevent      = (t == 25 || t == 28 || t == 31) ? 8'h01 :
                             (t == 18) ? 8'h04 : 8'h00;
            step();
            chk($sformatf("commit_ack_t%0d", t), 32'(cfg_commit_ack),
                32'(t == 25 || t == 31));
        end
        cfg_commit_req = 1'b0;
        maskevent      = 8'h00;
        chk("commit_still_run", 32'(seq_state), 32'd3);

        // Drain: stop, a commit during drain, reference event 7 cycles later.
        for (int t = 0; t < 9; t++) begin
            stop_req       = (t == 0);
            cfg_commit_req = (t == 2);
            maskevent      = (t == 7) ? 8'h01 : 8'h00;
            step();
            if (t < 7)
                chk($sformatf("drain_t%0d", t), 32'(obs()),
                    32'(rsp(3'd4, 0, 0, 1, 8'h05, 1, 0)));
            else if (t == 7)
                chk("drain_exit", 32'(obs()), 32'(rsp(3'd0, 0, 1, 0, 8'h00, 0, 0)));
            else
                chk("idle_after_drain", 32'(obs()), 32'(rsp(3'd0, 0, 0, 0, 8'h00, 0, 0)));
        end
        stop_req       = 1'b0;
        cfg_commit_req = 1'b0;
        maskevent      = 8'h00;

        // Watchdog: no mask events in RUN with limit 100.
        wdog_lim = 24'd100;
        run_up(8'h01, 16'd0);
        for (int n = 1; n <= 101; n++) begin
            step();
            if (n == 100)
                chk("wdog_not_yet", 32'(seq_state), 32'd3);
            if (n == 101)
                chk("wdog_fault", 32'(obs()), 32'(rsp(3'd5, 0, 0, 0, 8'h00, 0, 1)));
        end
        estop    = 1'b1;
        stop_req = 1'b1;
        step();
        chk("fault_hold_estop", 32'(seq_state), 32'd5);
        estop     = 1'b0;
        stop_req  = 1'b0;
        start_req = 1'b1;
        step();
        chk("fault_ignore_start", 32'(seq_state), 32'd5);
        start_req = 1'b0;
        stop_req  = 1'b1;
        step();
        chk("fault_exit", 32'(obs()), 32'(rsp(3'd0, 0, 0, 0, 8'h00, 0, 0)));
        stop_req = 1'b0;
        wdog_lim = 24'd0;

        // Emergency stop during STAGGER once the first of three channels is on.
        begin
            int n;
            carr_enable = 8'h25;
            stagger     = 16'd3;
            start_req   = 1'b1;
            step();
            start_req = 1'b0;
            n = 0;
            while (carrier_onoff == 8'h00 && n < 20) begin
                step();
                n++;
            end
            chk("estop_first_on", 32'(carrier_onoff), 32'h01);
        end
        estop = 1'b1;
        step();
        chk("estop_fault", 32'(obs()), 32'(rsp(3'd5, 0, 0, 0, 8'h00, 0, 1)));
        start_req = 1'b1;
        step();
        chk("estop_start_ign1", 32'(seq_state), 32'd5);
        estop = 1'b0;
        step();
        chk("estop_start_ign2", 32'(seq_state), 32'd5);
        start_req = 1'b0;
        stop_req  = 1'b1;
        step();
        chk("estop_exit", 32'(obs()), 32'(rsp(3'd0, 0, 0, 0, 8'h00, 0, 0)));
        stop_req = 1'b0;

        // Async reset mid-RUN with a commit pending.
        run_up(8'h01, 16'd0);
        cfg_commit_req = 1'b1;
        step();
        cfg_commit_req = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset", 32'(obs()), 32'(rsp(3'd0, 0, 0, 0, 8'h00, 0, 0)));
        step();
        step();
        reset     = 1'b1;
        maskevent = 8'h01;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("post_reset_%0d", n), 32'({cfg_commit_ack, seq_state}), 32'd0);
        end
        maskevent = 8'h00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
